// File: rtl/alu_share_pkg.sv
// alu_share_pkg: shared opcodes, FSM states and defaults
// for the two-requester ALU share controller.
package alu_share_pkg;

  localparam int DW_DEF = 32;

  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_OR  = 3'b111;
  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic op_illegal(
    input logic [2:0] op
  );
    return op[2:1] == 2'b01;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin grant. A lone requester
// wins outright; on contention the pointer decides.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_ptr,
  output logic       o_gnt,
  output logic       o_any
);

  assign o_any = |i_valid;
  assign o_gnt = (&i_valid) ? i_ptr : i_valid[1];

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: time-shares one ALU between two requesters.
// Optional macro ALU_SHARE_OPCHK_EN adds illegal-op detection.
module alu_share_ctrl
  import alu_share_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [2:0]    req0_op,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [2:0]    req1_op,
  output logic          rsp0_valid,
  input  logic          rsp0_ready,
  output logic [DW-1:0] rsp0_data,
  output logic          rsp1_valid,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp1_data,
`ifdef ALU_SHARE_OPCHK_EN
  output logic          rsp0_err,
  output logic          rsp1_err,
`endif
  output logic [DW-1:0] alu_i1,
  output logic [DW-1:0] alu_i2,
  output logic [2:0]    alu_aluop,
  input  logic [DW-1:0] alu_o
);

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_ptr;
  logic          r_gid;
  logic [3:0]    r_cnt;
  logic [DW-1:0] r_d0;
  logic [DW-1:0] r_d1;
  logic [DW-1:0] r_i1;
  logic [DW-1:0] r_i2;
  logic [2:0]    r_op;

  logic          w_gnt;
  logic          w_any;
  logic          w_acc;
  logic          w_hs;
  logic          w_ill;
  logic [DW-1:0] w_a;
  logic [DW-1:0] w_b;
  logic [2:0]    w_op;

  rr_arb2 u_arb (
    .i_valid ({req1_valid, req0_valid}),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_any   (w_any)
  );

  assign w_a  = w_gnt ? req1_a  : req0_a;
  assign w_b  = w_gnt ? req1_b  : req0_b;
  assign w_op = w_gnt ? req1_op : req0_op;

`ifdef ALU_SHARE_OPCHK_EN
  assign w_ill = op_illegal(w_op);
`else
  assign w_ill = 1'b0;
`endif

  assign w_acc = (r_state == S_IDLE) & w_any & ~rst;
  assign w_hs  = (r_state == S_RESP) &
                 (r_gid ? rsp1_ready : rsp0_ready);

  assign req0_ready = w_acc & ~w_gnt;
  assign req1_ready = w_acc &  w_gnt;
  assign rsp0_valid = (r_state == S_RESP) & ~r_gid;
  assign rsp1_valid = (r_state == S_RESP) &  r_gid;
  assign rsp0_data  = r_d0;
  assign rsp1_data  = r_d1;
  assign alu_i1     = r_i1;
  assign alu_i2     = r_i2;
  assign alu_aluop  = r_op;

`ifdef ALU_SHARE_OPCHK_EN
  logic r_err;
  assign rsp0_err = r_err & rsp0_valid;
  assign rsp1_err = r_err & rsp1_valid;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // FSM next state: illegal ops skip EXEC entirely
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_acc) w_next = w_ill ? S_RESP : S_EXEC;
      S_EXEC: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP: if (w_hs) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand launch, latency count, result capture, rr pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
      r_gid <= 1'b0;
      r_cnt <= 4'd0;
      r_d0  <= '0;
      r_d1  <= '0;
      r_i1  <= '0;
      r_i2  <= '0;
      r_op  <= OP_ADD;
`ifdef ALU_SHARE_OPCHK_EN
      r_err <= 1'b0;
`endif
    end else begin
      if (w_acc) begin
        r_gid <= w_gnt;
        r_cnt <= LAT_M1;
        if (!w_ill) begin
          r_i1 <= w_a;
          r_i2 <= w_b;
          r_op <= w_op;
        end
`ifdef ALU_SHARE_OPCHK_EN
        r_err <= w_ill;
        if (w_ill) begin
          if (w_gnt) r_d1 <= '0;
          else       r_d0 <= '0;
        end
`endif
      end
      if (r_state == S_EXEC) begin
        if (r_cnt == 4'd0) begin
          if (r_gid) r_d1 <= alu_o;
          else       r_d0 <= alu_o;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
      if (w_hs) r_ptr <= ~r_gid;
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed + random bench with a
// transaction-level model of the shared-ALU controller.
module tb_alu_share_ctrl;
  import alu_share_pkg::*;

  localparam int LAT = 4;
`ifdef ALU_SHARE_OPCHK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready;
  logic [31:0] req0_a, req0_b;
  logic [2:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [31:0] req1_a, req1_b;
  logic [2:0]  req1_op;
  logic        rsp0_valid, rsp0_ready;
  logic [31:0] rsp0_data;
  logic        rsp1_valid, rsp1_ready;
  logic [31:0] rsp1_data;
`ifdef ALU_SHARE_OPCHK_EN
  logic        rsp0_err, rsp1_err;
  logic [1:0]  hs_e;
`endif
  logic [31:0] alu_i1, alu_i2, alu_o;
  logic [2:0]  alu_aluop;

  always #5 clk = ~clk;

  alu_share_ctrl #(.DW(32), .ALU_LAT(LAT)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_data  (rsp0_data),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_data  (rsp1_data),
`ifdef ALU_SHARE_OPCHK_EN
    .rsp0_err   (rsp0_err),
    .rsp1_err   (rsp1_err),
`endif
    .alu_i1     (alu_i1),
    .alu_i2     (alu_i2),
    .alu_aluop  (alu_aluop),
    .alu_o      (alu_o)
  );

  function automatic logic [31:0] alu_f(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  op
  );
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_AND: return a & b;
      OP_OR:  return a | b;
      OP_SLL: return (b >= 32) ? 32'd0 : a << b[4:0];
      OP_SRL: return (b >= 32) ? 32'd0 : a >> b[4:0];
      default: return a ^ b;
    endcase
  endfunction

  assign alu_o = alu_f(alu_i1, alu_i2, alu_aluop);

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  bit          m_busy, m_who, m_ill, m_pref, m_e;
  int          m_acc;
  logic [31:0] m_res, m_i1, m_i2;
  logic [2:0]  m_op;
  logic [31:0] m_d [2];
  bit   [1:0]  m_dk;

  logic [1:0]  o_rdy, o_val;
  bit          hold0, hold1;
  int          ord_q[$];
  logic [31:0] hs_d [2];
  int          hs_n [2];

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h",
               tag, cyc_n, got, exp);
    end
  endtask

  task automatic mreset();
    m_busy = 0;
    m_pref = 0;
    m_e    = 0;
    m_d[0] = '0;
    m_d[1] = '0;
    m_dk   = 2'b11;
    m_i1   = '0;
    m_i2   = '0;
    m_op   = OP_ADD;
  endtask

  task automatic cyc();
    logic [1:0]  er, ev;
    bit          g;
    int          le;
    logic [31:0] a, b;
    logic [2:0]  op;
    #1;
    er = '0;
    ev = '0;
    if (m_busy) begin
      le = (OPCHK && m_ill) ? 0 : LAT;
      if (cyc_n - m_acc >= le) begin
        ev[m_who]  = 1'b1;
        m_d[m_who] = m_res;
        m_dk[m_who] = !m_ill || OPCHK;
        m_e = m_ill && OPCHK;
      end
    end else if (!rst && (req0_valid || req1_valid)) begin
      g = (req0_valid && req1_valid) ? m_pref : req1_valid;
      er[g] = 1'b1;
    end
    chk("rdy0", 32'(req0_ready), 32'(er[0]));
    chk("rdy1", 32'(req1_ready), 32'(er[1]));
    chk("one_rdy", 32'(req0_ready & req1_ready), 32'd0);
    chk("val0", 32'(rsp0_valid), 32'(ev[0]));
    chk("val1", 32'(rsp1_valid), 32'(ev[1]));
    if (m_dk[0]) chk("dat0", rsp0_data, m_d[0]);
    if (m_dk[1]) chk("dat1", rsp1_data, m_d[1]);
    chk("alu_i1", alu_i1, m_i1);
    chk("alu_i2", alu_i2, m_i2);
    chk("alu_op", 32'(alu_aluop), 32'(m_op));
`ifdef ALU_SHARE_OPCHK_EN
    chk("err0", 32'(rsp0_err), 32'(ev[0] & m_e));
    chk("err1", 32'(rsp1_err), 32'(ev[1] & m_e));
`endif
    o_rdy = {req1_ready, req0_ready};
    o_val = {rsp1_valid, rsp0_valid};
    if (rsp0_valid && rsp0_ready) begin
      hs_d[0] = rsp0_data;
      hs_n[0]++;
`ifdef ALU_SHARE_OPCHK_EN
      hs_e[0] = rsp0_err;
`endif
    end
    if (rsp1_valid && rsp1_ready) begin
      hs_d[1] = rsp1_data;
      hs_n[1]++;
`ifdef ALU_SHARE_OPCHK_EN
      hs_e[1] = rsp1_err;
`endif
    end
    if (rst) begin
      mreset();
    end else if (|er) begin
      g  = er[1];
      a  = g ? req1_a  : req0_a;
      b  = g ? req1_b  : req0_b;
      op = g ? req1_op : req0_op;
      m_busy = 1;
      m_who  = g;
      m_acc  = cyc_n + 1;
      m_ill  = (op[2:1] == 2'b01);
      if (OPCHK && m_ill) begin
        m_res = '0;
      end else begin
        m_res = alu_f(a, b, op);
        m_i1  = a;
        m_i2  = b;
        m_op  = op;
      end
    end else if (m_busy && ev[m_who] &&
                 (m_who ? rsp1_ready : rsp0_ready)) begin
      m_busy = 0;
      m_pref = !m_who;
    end
    @(posedge clk);
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic tick();
    cyc();
    if (o_rdy[0]) begin
      ord_q.push_back(0);
      if (!hold0) req0_valid = 0;
    end
    if (o_rdy[1]) begin
      ord_q.push_back(1);
      if (!hold1) req1_valid = 0;
    end
  endtask

  task automatic do_rst();
    req0_valid = 0;
    req1_valid = 0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic one(
    input bit          p,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [2:0]  op,
    input logic [31:0] exp,
    input bit          ck,
    input string       tag
  );
    int n;
    n = hs_n[p];
    if (p) begin
      req1_a = a; req1_b = b; req1_op = op;
      req1_valid = 1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op;
      req0_valid = 1;
    end
    rsp0_ready = 1;
    rsp1_ready = 1;
    for (int i = 0; i < 40 && hs_n[p] == n; i++) tick();
    chk({tag, "_hs"}, 32'(hs_n[p] - n), 32'd1);
    if (ck) chk(tag, hs_d[p], exp);
  endtask

  function automatic logic [2:0] rop();
    int k;
    k = OPCHK ? $urandom_range(0, 7) : $urandom_range(0, 5);
    case (k)
      0: return OP_ADD;
      1: return OP_SUB;
      2: return OP_AND;
      3: return OP_OR;
      4: return OP_SLL;
      5: return OP_SRL;
      6: return 3'b010;
      default: return 3'b011;
    endcase
  endfunction

  function automatic logic [31:0] rb(input logic [2:0] op);
    if (op[2:1] == 2'b00 && $urandom_range(0, 3) != 0)
      return 32'($urandom_range(0, 40));
    return $urandom;
  endfunction

  initial begin
    #1000000;
    $display("FAIL timeout cyc=%0d", cyc_n);
    $fatal(1, "timeout");
  end

  initial begin
    int acyc, vcyc, nrdy, n0;
    bit v1seen;
    logic [31:0] dsave;
    rst = 1;
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    hold0 = 0; hold1 = 0;
    hs_n[0] = 0; hs_n[1] = 0;
    hs_d[0] = '0; hs_d[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    mreset();
    // reset state, ready must stay low while rst is high
    tick();
    req0_valid = 1;
    tick();
    req0_valid = 0;
    rst = 0;

    // single add on port 0
    req0_a = 5; req0_b = 7; req0_op = OP_ADD;
    req0_valid = 1;
    rsp0_ready = 1;
    rsp1_ready = 1;
    acyc = -1; vcyc = -1; nrdy = 0; v1seen = 0;
    n0 = hs_n[0];
    for (int i = 0; i < 20; i++) begin
      tick();
      if (o_rdy[0]) begin
        nrdy++;
        acyc = cyc_n - 1;
      end
      if (o_val[0] && vcyc < 0) vcyc = cyc_n - 1;
      if (o_val[1]) v1seen = 1;
    end
    chk("t1_nrdy", 32'(nrdy), 32'd1);
    chk("t1_lat", 32'(vcyc - acyc - 1), 32'(LAT));
    chk("t1_hs", 32'(hs_n[0] - n0), 32'd1);
    chk("t1_dat", hs_d[0], 32'd12);
    chk("t1_v1", 32'(v1seen), 32'd0);

    // both held from reset: alternate grants
    do_rst();
    ord_q.delete();
    hold0 = 1; hold1 = 1;
    req0_a = 10; req0_b = 3; req0_op = OP_SUB;
    req1_a = 32'hF0; req1_b = 32'h3C; req1_op = OP_AND;
    req0_valid = 1;
    req1_valid = 1;
    for (int i = 0; i < 40 && ord_q.size() < 4; i++) tick();
    hold0 = 0; hold1 = 0;
    req0_valid = 0; req1_valid = 0;
    chk("t2_cnt", 32'(ord_q.size()), 32'd4);
    for (int k = 0; k < 4 && k < ord_q.size(); k++)
      chk("t2_ord", 32'(ord_q[k]), 32'(k % 2));
    repeat (12) tick();
    chk("t2_d0", hs_d[0], 32'd7);
    chk("t2_d1", hs_d[1], 32'h30);

    // response backpressure while req1 waits
    req0_a = $urandom; req0_b = $urandom; req0_op = OP_ADD;
    req0_valid = 1;
    rsp0_ready = 0;
    o_val = '0;
    for (int i = 0; i < 20 && !o_val[0]; i++) tick();
    req1_a = 32'h0F0F; req1_b = 32'h1000; req1_op = OP_OR;
    req1_valid = 1;
    dsave = rsp0_data;
    chk("t3_dat", dsave, req0_a + req0_b);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_v0", 32'(o_val[0]), 32'd1);
      chk("t3_r1", 32'(o_rdy[1]), 32'd0);
      chk("t3_d0", rsp0_data, dsave);
    end
    rsp0_ready = 1;
    tick();
    tick();
    chk("t3_acc1", 32'(o_rdy[1]), 32'd1);
    repeat (10) tick();
    chk("t3_d1", hs_d[1], 32'h1F0F);

    // shift and wrap boundaries
    one(0, 32'd1, 32'd31, OP_SLL, 32'h80000000, 1, "sll31");
    one(0, 32'h80000000, 32'd4, OP_SRL,
        32'h08000000, 1, "srl4");
    one(1, 32'd1, 32'd32, OP_SLL, 32'd0, 1, "sll32");
    one(1, 32'hFFFFFFFF, 32'd1, OP_ADD, 32'd0, 1, "addwrap");
    one(0, 32'd3, 32'd5, OP_SUB, 32'hFFFFFFFE, 1, "subneg");

    // reset mid-EXEC discards the op and re-favours req0
    do_rst();
    one(0, 32'd2, 32'd2, OP_ADD, 32'd4, 1, "t5_pre");
    req0_a = 9; req0_b = 9; req0_op = OP_SUB;
    req0_valid = 1;
    o_rdy = '0;
    for (int i = 0; i < 10 && !o_rdy[0]; i++) tick();
    tick();
    tick();
    n0 = hs_n[0];
    rst = 1;
    tick();
    rst = 0;
    chk("t5_i1", alu_i1, 32'd0);
    chk("t5_op", 32'(alu_aluop), 32'(OP_ADD));
    repeat (8) tick();
    chk("t5_nohs", 32'(hs_n[0] - n0), 32'd0);
    ord_q.delete();
    req0_a = 1; req0_b = 1; req0_op = OP_OR;
    req1_a = 2; req1_b = 2; req1_op = OP_AND;
    req0_valid = 1;
    req1_valid = 1;
    for (int i = 0; i < 10 && ord_q.size() < 1; i++) tick();
    chk("t5_first", 32'(ord_q.size() > 0 ? ord_q[0] : 9),
        32'd0);
    for (int i = 0; i < 30 && ord_q.size() < 2; i++) tick();
    repeat (10) tick();

    // illegal opcode on req1
    one(1, 32'h11, 32'h22, 3'b010, 32'd0, OPCHK, "ill");
`ifdef ALU_SHARE_OPCHK_EN
    chk("t6_err", 32'(hs_e[1]), 32'd1);
`else
    chk("t6_op", 32'(alu_aluop), 32'(3'b010));
`endif

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_a = $urandom;
        req0_op = rop();
        req0_b = rb(req0_op);
        req0_valid = 1;
      end else if (req0_valid && $urandom_range(0, 15) == 0) begin
        req0_valid = 0;
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_a = $urandom;
        req1_op = rop();
        req1_b = rb(req1_op);
        req1_valid = 1;
      end else if (req1_valid && $urandom_range(0, 15) == 0) begin
        req1_valid = 0;
      end
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 0;
    req0_valid = 0;
    req1_valid = 0;
    rsp0_ready = 1;
    rsp1_ready = 1;
    repeat (10) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Two-requester controller that time-shares the single 32-bit `alu` instance.
- Requesters are the pipeline execute stage on port 0 and the address/branch helper on port 1.
- Round-robin arbitration with valid/ready handshakes on request and response sides.
- Registers operands and opcode onto the ALU, waits a fixed ALU latency, captures the result and returns it to the granted requester.

Parameters:
- DW, 32, datapath width; must match the ALU operand width.
- ALU_LAT, 1, number of clk cycles from operands registered on the ALU inputs to the ALU output being sampled; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle
- req0_a / req1_a  in  DW  operand A (shifts: value to shift)
- req0_b / req1_b  in  DW  operand B (shifts: shift amount, full width)
- req0_op / req1_op  in  3  opcode: 100 add, 101 sub, 110 and, 111 or, 000 sll, 001 srl
- rsp0_valid / rsp1_valid  out  1  result available
- rsp0_ready / rsp1_ready  in  1  requester takes result
- rsp0_data / rsp1_data  out  DW  result
- alu_i1  out  DW  to ALU i1
- alu_i2  out  DW  to ALU i2
- alu_aluop  out  3  to ALU aluop
- alu_o  in  DW  from ALU o

Behaviour:
- Reset state:
  - Reset is synchronous, active-high.
  - State IDLE, rr_ptr=0 (req0 favoured), counter=0.
  - alu_i1=0, alu_i2=0, alu_aluop=3'b100.
  - Result register 0; rspN_valid=0.
  - reqN_ready=0 while rst is high.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant selection: if only one reqN_valid, grant it; if both, grant rr_ptr.
  - reqN_ready is combinational: state==IDLE && !rst && grant==N && reqN_valid. At most one ready is high per cycle.
  - On handshake at edge T: register a/b/op onto alu_i1/alu_i2/alu_aluop, store grant id, counter=ALU_LAT-1, go to EXEC.
- EXEC:
  - ALU outputs are held stable.
  - Counter decrements each cycle.
  - On the cycle counter==0, capture alu_o into the result register and go to RESP. The capture edge is T+ALU_LAT.
- RESP:
  - rspG_valid=1 for the granted requester only; rsp_data holds the captured result.
  - rspN_data of the non-granted port holds its last value.
  - Wait indefinitely for rspG_ready.
  - On handshake: go to IDLE and set rr_ptr to the other requester.
- Latency and throughput:
  - Accept to rsp_valid is ALU_LAT cycles.
  - Throughput is one op per ALU_LAT+2 cycles; there is one idle bubble after each response.
- ALU operands stay unchanged from accept until the next accept; they are not cleared.
- Requesters may drop reqN_valid before ready with no side effect. Requester operands need not be held after handshake.
- A single outstanding op exists in the controller. No new request is accepted in EXEC or RESP.
- The ALU computes modulo 2^DW with no carry/overflow output. Shifts use the full B value; B>=32 yields 0.
- rst mid-EXEC or mid-RESP: the op is discarded, no response is issued, all reset values apply from the next cycle, and rr_ptr returns to 0.
- rsp_ready asserted while rsp_valid is low is ignored.

Optional Feature:
- Macro: ALU_SHARE_OPCHK_EN
- When defined:
  - Opcodes 010 and 011 are illegal.
  - The illegal request is still accepted, but the ALU is not driven and EXEC is skipped.
  - Next state is RESP with rsp_data=0 and rspN_err=1.
  - New outputs rsp0_err and rsp1_err (1 bit each) reset to 0 and are valid only with rspN_valid.
- When undefined:
  - No err ports exist.
  - Illegal opcodes are forwarded to the ALU unchanged.
  - The response data is whatever alu_o holds at capture; the bench must not check its value.

Decomposition:
- Package alu_share_pkg:
  - Opcode constants OP_ADD=3'b100, OP_SUB=3'b101, OP_AND=3'b110, OP_OR=3'b111, OP_SLL=3'b000, OP_SRL=3'b001.
  - State encoding IDLE/EXEC/RESP.
  - Default DW.
- One sub-module, rr_arb2: two-way round-robin grant with inputs valid[1:0] and ptr, outputs grant id and any.

Test Plan:
- req0 only, a=5, b=7, op=100, ALU_LAT=1 -> req0_ready for 1 cycle; rsp0_valid 1 cycle after accept, rsp0_data=12; rsp1_valid stays 0.
- Both valid from reset and held; req0: 10 sub 3; req1: 0xF0 and 0x3C -> grant order 0,1,0,1; rsp0_data=7, rsp1_data=0x30; ready never high on both ports in the same cycle.
- Backpressure: rsp0_ready low for 5 cycles with req1_valid high -> rsp0_valid and rsp0_data stable, req1_ready=0 throughout; req1 is accepted the cycle after IDLE is re-entered.
- Shifts -> 1 sll 31 = 0x80000000; 0x80000000 srl 4 = 0x08000000; 1 sll 32 = 0; 0xFFFFFFFF add 1 = 0.
- rst pulsed during EXEC with ALU_LAT=4 -> no rsp_valid ever for that op; alu_i1=0, alu_aluop=100; next simultaneous requests are granted to req0 first.
- ALU_SHARE_OPCHK_EN defined, req1 op=010 -> rsp1_valid with rsp1_err=1, rsp1_data=0, alu_* unchanged. Without the macro -> op is forwarded, alu_aluop=010, and the response still handshakes.
